// File: rtl/sequence_player_if.sv
// -----------------------------------------------------------------------------
// sequence_player_if
//   Bundles the round-controller handshake, the seq ROM read port and the LED
//   output of the sequence player.
//   start     : one-cycle request to play a round (controller -> player)
//   round_len : number of ROM entries to play, latched with start
//   rd_addr   : registered ROM read address (player -> ROM)
//   rd_data   : synchronous ROM data, valid one cycle after rd_addr
//   led       : one-hot colour output
//   busy      : playback in progress
//   done      : one-cycle completion pulse
//   Modports: slave = the sequence player, master = its surroundings.
// -----------------------------------------------------------------------------
interface sequence_player_if;
  logic       start;
  logic [3:0] round_len;
  logic [3:0] rd_addr;
  logic [1:0] rd_data;
  logic [3:0] led;
  logic       busy;
  logic       done;

  modport slave (
    input  start, round_len, rd_data,
    output rd_addr, led, busy, done
  );

  modport master (
    output start, round_len, rd_data,
    input  rd_addr, led, busy, done
  );
endinterface

// File: rtl/sequence_player.sv
// -----------------------------------------------------------------------------
// sequence_player
//   Plays back the first round_len entries of the seq ROM as one-hot LED
//   flashes: each entry is fetched (FETCH, WAIT), shown for ON_CYCLES and
//   followed by an OFF_CYCLES dark gap. Reports busy and a one-cycle done.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : sequence_player_if.slave (start, round_len, rd_addr, rd_data,
//           led, busy, done)
// -----------------------------------------------------------------------------
module sequence_player #(
  parameter int N          = 10,
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  sequence_player_if.slave  bus
);

  localparam int CNT_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  // Keep at least one bit so ON=OFF=1 still yields a legal counter.
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [3:0]       N_LEN    = 4'(N);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] SHOW  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;
  localparam logic [2:0] FIN   = 3'd5;

  logic [2:0]       state;
  logic [3:0]       idx;
  logic [3:0]       len;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       rd_addr;
  logic [3:0]       led;
  logic             busy;
  logic [3:0]       idx_next;

  assign idx_next = idx + 4'd1;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      len     <= '0;
      cnt     <= '0;
      rd_addr <= '0;
      led     <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            len     <= (bus.round_len > N_LEN) ? N_LEN : bus.round_len;
            idx     <= '0;
            rd_addr <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= (bus.round_len == 4'd0) ? FIN : FETCH;
          end
        end
        FETCH: begin
          rd_addr <= idx;
          state   <= WAIT;
        end
        WAIT: begin
          led   <= 4'b0001 << bus.rd_data;
          cnt   <= '0;
          state <= SHOW;
        end
        SHOW: begin
          if (cnt == ON_LAST) begin
            led   <= '0;
            cnt   <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == OFF_LAST) begin
            cnt <= '0;
            // On the last entry idx/rd_addr are left alone so they never
            // step past N-1.
            if (idx_next == len) begin
              state <= FIN;
            end else begin
              idx     <= idx_next;
              rd_addr <= idx_next;
              state   <= FETCH;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          led   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd_addr = rd_addr;
  assign bus.led     = led;
  assign bus.busy    = busy;
  // done is decoded from the state so it is high exactly for the FIN cycle.
  assign bus.done    = (state == FIN);

endmodule

// File: tb/tb_sequence_player.sv
// -----------------------------------------------------------------------------
// tb_sequence_player
//   Directed bench for sequence_player with N=10, ON=4, OFF=2 and a
//   synchronous ROM holding {2,0,3,1,2,2,1,0,3,1}. Each entry occupies 8
//   cycles after start: FETCH, WAIT, 4 lit, 2 dark; FIN follows the last.
// -----------------------------------------------------------------------------
module tb_sequence_player;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sequence_player_if sp_if ();

  sequence_player #(
    .N          (10),
    .ON_CYCLES  (4),
    .OFF_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sp_if)
  );

  logic [1:0] rom [0:15];
  always @(posedge clk) sp_if.rd_data <= rom[sp_if.rd_addr];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge while the player is idle. Pulses start and checks
  // every following cycle up to and including FIN; returns at FIN's negedge.
  // repulse_c > 0 re-asserts start (with a different round_len) after that cycle.
  task automatic run_round(input int rl, input int exp_len, input int repulse_c, input string name);
    int         last;
    int         busy_cnt;
    int         max_addr;
    int         ent;
    int         k;
    logic [3:0] exp_led;
    last     = exp_len * 8 + 1;
    busy_cnt = 0;
    max_addr = 0;
    sp_if.round_len = 4'(rl);
    sp_if.start     = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      sp_if.start = (c == repulse_c);
      if (c == repulse_c) sp_if.round_len = 4'd7;
      ent = (c - 1) / 8;
      k   = (c - 1) % 8 + 1;
      exp_led = (c < last && k >= 3 && k <= 6) ? (4'b0001 << rom[ent]) : 4'b0000;
      check($sformatf("%s led c=%0d", name, c), sp_if.led, exp_led);
      check($sformatf("%s done c=%0d", name, c), sp_if.done, (c == last));
      if (sp_if.busy === 1'b1) busy_cnt++;
      if (int'(sp_if.rd_addr) > max_addr) max_addr = int'(sp_if.rd_addr);
    end
    sp_if.start = 1'b0;
    check($sformatf("%s busy_cycles", name), busy_cnt, last);
    if (exp_len > 0) check($sformatf("%s max_rd_addr", name), max_addr, exp_len - 1);
  endtask

  task automatic check_idle(input string name);
    check($sformatf("%s idle busy", name), sp_if.busy, 1'b0);
    check($sformatf("%s idle done", name), sp_if.done, 1'b0);
    check($sformatf("%s idle led", name), sp_if.led, 4'b0000);
  endtask

  initial begin
    rom[0] = 2'd2; rom[1] = 2'd0; rom[2] = 2'd3; rom[3] = 2'd1; rom[4] = 2'd2;
    rom[5] = 2'd2; rom[6] = 2'd1; rom[7] = 2'd0; rom[8] = 2'd3; rom[9] = 2'd1;
    for (int i = 10; i < 16; i++) rom[i] = 2'd0;

    reset           = 1'b1;
    sp_if.start     = 1'b0;
    sp_if.round_len = 4'd0;
    repeat (2) @(negedge clk);
    check("reset rd_addr", sp_if.rd_addr, 4'd0);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle("post-reset");

    // len=3: 0100, 0001, 1000 flashes, busy 25 cycles.
    run_round(3, 3, 0, "len3");
    @(negedge clk);
    check_idle("len3");

    // len=0: no LEDs, busy and done for one cycle.
    run_round(0, 0, 0, "len0");
    @(negedge clk);
    check_idle("len0");

    // round_len=15 clamps to 10 entries, busy 81 cycles, rd_addr max 9.
    run_round(15, 10, 0, "len15");
    @(negedge clk);
    check_idle("len15");

    // start and round_len change during SHOW of entry 1 are ignored.
    run_round(3, 3, 12, "repulse");
    @(negedge clk);
    check_idle("repulse");

    // start raised during FIN is ignored.
    run_round(1, 1, 0, "finstart");
    sp_if.round_len = 4'd2;
    sp_if.start     = 1'b1;
    @(negedge clk);
    sp_if.start = 1'b0;
    check_idle("finstart");
    @(negedge clk);
    check_idle("finstart+1");

    // Back-to-back: second round started in the IDLE cycle right after FIN.
    run_round(1, 1, 0, "b2b_a");
    @(negedge clk);
    check_idle("b2b_a");
    run_round(2, 2, 0, "b2b_b");
    @(negedge clk);
    check_idle("b2b_b");

    // Reset during the first GAP cycle of entry 2 (cycle 23 after start).
    sp_if.round_len = 4'd5;
    sp_if.start     = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      sp_if.start = 1'b0;
    end
    check("abort pre busy", sp_if.busy, 1'b1);
    check("abort pre led", sp_if.led, 4'b0000);
    reset = 1'b1;
    #1;
    check("abort rd_addr", sp_if.rd_addr, 4'd0);
    check_idle("abort");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_idle($sformatf("abort quiet%0d", c));
    end
    run_round(3, 3, 0, "replay");
    @(negedge clk);
    check_idle("replay");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
